jtag_tap_ctrl: RTL and testbench

IEEE 1149.1 Test Access Port controller that sits directly upstream of the DMI JTAG stage. It decodes TMS into the 16-state TAP state machine and holds the instruction register. It implements the IDCODE and BYPASS data registers locally. For the DTMCS and DMI registers, it drives capture/shift/update strobes and select lines and multiplexes their serial outputs onto TDO.

---
 rtl/jtag_tap_ctrl.sv | 178 +++++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - IEEE 1149.1 TAP controller feeding the DMI JTAG stage
// Define JTAG_TAP_IDCODE_EN to implement the IDCODE data register.
module jtag_tap_ctrl #(
  parameter int unsigned IrLength    = 5,
  parameter logic [31:0] IdcodeValue = 32'h00000001
) (
  input  logic tck_i,
  input  logic trst_ni,
  input  logic tms_i,
  input  logic td_i,
  output logic td_o,
  output logic tdo_oe_o,
  output logic tck_o,
  output logic dmi_clear_o,
  output logic capture_o,
  output logic shift_o,
  output logic update_o,
  output logic tdi_o,
  output logic dtmcs_select_o,
  input  logic dtmcs_tdo_i,
  output logic dmi_select_o,
  input  logic dmi_tdo_i
);

  typedef enum logic [3:0] {
    TestLogicReset, RunTestIdle, SelectDrScan, CaptureDr, ShiftDr, Exit1Dr,
    PauseDr, Exit2Dr, UpdateDr, SelectIrScan, CaptureIr, ShiftIr, Exit1Ir,
    PauseIr, Exit2Ir, UpdateIr
  } tap_state_e;

  localparam logic [IrLength-1:0] IrIdcode    = IrLength'(5'h01);
  localparam logic [IrLength-1:0] IrDtmcs     = IrLength'(5'h10);
  localparam logic [IrLength-1:0] IrDmiAccess = IrLength'(5'h11);
  localparam logic [IrLength-1:0] IrCapture   = IrLength'(3'b101);
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IrLength-1:0] IrReset     = IrIdcode;
`else
  localparam logic [IrLength-1:0] IrReset     = '1;
`endif

  tap_state_e          state_q, state_d;
  logic [IrLength-1:0] ir_q, ir_shift_q;
  logic                bypass_q;
  logic                dtmcs_sel, dmi_sel, idcode_sel, bypass_sel;
  logic                tdo_mux;

  assign tck_o = tck_i;
  assign tdi_o = td_i;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q <= TestLogicReset;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   state_d = tms_i ? SelectIrScan   : CaptureDr;
      CaptureDr:      state_d = tms_i ? Exit1Dr        : ShiftDr;
      ShiftDr:        state_d = tms_i ? Exit1Dr        : ShiftDr;
      Exit1Dr:        state_d = tms_i ? UpdateDr       : PauseDr;
      PauseDr:        state_d = tms_i ? Exit2Dr        : PauseDr;
      Exit2Dr:        state_d = tms_i ? UpdateDr       : ShiftDr;
      UpdateDr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms_i ? Exit1Ir        : ShiftIr;
      ShiftIr:        state_d = tms_i ? Exit1Ir        : ShiftIr;
      Exit1Ir:        state_d = tms_i ? UpdateIr       : PauseIr;
      PauseIr:        state_d = tms_i ? Exit2Ir        : PauseIr;
      Exit2Ir:        state_d = tms_i ? UpdateIr       : ShiftIr;
      UpdateIr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      default:        state_d = TestLogicReset;
    endcase
  end

  // Strobes are deliberately not gated by IR; downstream qualifies with the selects.
  always_comb begin
    dmi_clear_o = (state_q == TestLogicReset);
    capture_o   = (state_q == CaptureDr);
    shift_o     = (state_q == ShiftDr);
    update_o    = (state_q == UpdateDr);
  end

  assign dtmcs_sel = (ir_q == IrDtmcs);
  assign dmi_sel   = (ir_q == IrDmiAccess);
`ifdef JTAG_TAP_IDCODE_EN
  assign idcode_sel = (ir_q == IrIdcode);
`else
  assign idcode_sel = 1'b0;
  logic unused_idcode;
  assign unused_idcode = ^{IdcodeValue, IrIdcode};
`endif
  assign bypass_sel     = !(dtmcs_sel || dmi_sel || idcode_sel);
  assign dtmcs_select_o = dtmcs_sel;
  assign dmi_select_o   = dmi_sel;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir_q       <= IrReset;
      ir_shift_q <= '0;
    end else begin
      if (state_q == TestLogicReset) begin
        ir_q <= IrReset;
      end else if (state_q == UpdateIr) begin
        ir_q <= ir_shift_q;
      end
      if (state_q == CaptureIr) begin
        ir_shift_q <= IrCapture;
      end else if (state_q == ShiftIr) begin
        ir_shift_q <= {td_i, ir_shift_q[IrLength-1:1]};
      end
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      bypass_q <= 1'b0;
    end else if (bypass_sel) begin
      if (state_q == CaptureDr) begin
        bypass_q <= 1'b0;
      end else if (state_q == ShiftDr) begin
        bypass_q <= td_i;
      end
    end
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] idcode_q;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      idcode_q <= '0;
    end else if (idcode_sel) begin
      if (state_q == CaptureDr) begin
        idcode_q <= IdcodeValue;
      end else if (state_q == ShiftDr) begin
        idcode_q <= {td_i, idcode_q[31:1]};
      end
    end
  end
`endif

  always_comb begin
    tdo_mux = 1'b0;
    if (state_q == ShiftIr) begin
      tdo_mux = ir_shift_q[0];
    end else if (state_q == ShiftDr) begin
      if (dtmcs_sel) begin
        tdo_mux = dtmcs_tdo_i;
      end else if (dmi_sel) begin
        tdo_mux = dmi_tdo_i;
`ifdef JTAG_TAP_IDCODE_EN
      end else if (idcode_sel) begin
        tdo_mux = idcode_q[0];
`endif
      end else begin
        tdo_mux = bypass_q;
      end
    end
  end

  // TDO launches on the falling edge so the probe samples it on the next rising edge.
  always_ff @(negedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      td_o     <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      td_o     <= tdo_mux;
      tdo_oe_o <= (state_q == ShiftIr) || (state_q == ShiftDr);
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb/tb_jtag_tap_ctrl.sv - self-checking bench for jtag_tap_ctrl (honours JTAG_TAP_IDCODE_EN)
module tb_jtag_tap_ctrl;

  logic tck = 1'b0;
  logic trst_ni = 1'b0;
  logic tms_i = 1'b1, td_i = 1'b0, dtmcs_tdo_i = 1'b0, dmi_tdo_i = 1'b0;
  logic td_o, tdo_oe_o, tck_o, dmi_clear_o, capture_o, shift_o, update_o, tdi_o;
  logic dtmcs_select_o, dmi_select_o;

  int checks = 0;
  int errors = 0;

  jtag_tap_ctrl dut (
    .tck_i(tck), .trst_ni(trst_ni), .tms_i(tms_i), .td_i(td_i), .td_o(td_o),
    .tdo_oe_o(tdo_oe_o), .tck_o(tck_o), .dmi_clear_o(dmi_clear_o), .capture_o(capture_o),
    .shift_o(shift_o), .update_o(update_o), .tdi_o(tdi_o), .dtmcs_select_o(dtmcs_select_o),
    .dtmcs_tdo_i(dtmcs_tdo_i), .dmi_select_o(dmi_select_o), .dmi_tdo_i(dmi_tdo_i)
  );

  always #5 tck = ~tck;

  localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7,
                 UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;
  localparam int K_BYP = 0, K_ID = 1, K_DTMCS = 2, K_DMI = 3;
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [4:0]  IR_RST = 5'h01;
  localparam logic [31:0] EXP_DR_AFTER_RESET = 32'h00000001;
  localparam logic [31:0] EXP_IR01_SCAN = 32'h01;
`else
  localparam logic [4:0]  IR_RST = 5'h1F;
  localparam logic [31:0] EXP_DR_AFTER_RESET = 32'h4B863CD2;
  localparam logic [31:0] EXP_IR01_SCAN = 32'h86;
`endif

  // TAP transition table, [state][tms]
  int tab [16][2];
  initial begin
    tab[TLR]  = '{RTI, TLR};   tab[RTI]  = '{RTI, SDR};
    tab[SDR]  = '{CDR, SIR};   tab[CDR]  = '{SHDR, E1DR};
    tab[SHDR] = '{SHDR, E1DR}; tab[E1DR] = '{PDR, UDR};
    tab[PDR]  = '{PDR, E2DR};  tab[E2DR] = '{SHDR, UDR};
    tab[UDR]  = '{RTI, SDR};   tab[SIR]  = '{CIR, TLR};
    tab[CIR]  = '{SHIR, E1IR}; tab[SHIR] = '{SHIR, E1IR};
    tab[E1IR] = '{PIR, UIR};   tab[PIR]  = '{PIR, E2IR};
    tab[E2IR] = '{SHIR, UIR};  tab[UIR]  = '{RTI, SDR};
  end

  function automatic int kind(input logic [4:0] ir);
    if (ir == 5'h10) return K_DTMCS;
    if (ir == 5'h11) return K_DMI;
`ifdef JTAG_TAP_IDCODE_EN
    if (ir == 5'h01) return K_ID;
`endif
    return K_BYP;
  endfunction

  // Model: selected DR is a variable-length register of m_drlen bits, LSB out first.
  int          m_state = TLR;
  logic [4:0]  m_ir = IR_RST;
  logic [4:0]  m_irsh = 5'd0;
  logic [31:0] m_dr = 32'd0;
  int          m_drlen = 1;
  logic        e_tdo = 1'b0, e_oe = 1'b0;

  always @(posedge tck or negedge trst_ni) begin
    if (!trst_ni) begin
      m_state <= TLR; m_ir <= IR_RST; m_irsh <= 5'd0; m_dr <= 32'd0; m_drlen <= 1;
    end else begin
      m_state <= tab[m_state][int'(tms_i)];
      case (m_state)
        TLR:  m_ir <= IR_RST;
        CIR:  m_irsh <= 5'd5;
        SHIR: m_irsh <= (m_irsh >> 1) | (5'(td_i) << 4);
        UIR:  m_ir <= m_irsh;
        CDR:
          if (kind(m_ir) == K_ID) begin
            m_dr <= 32'h00000001; m_drlen <= 32;
          end else if (kind(m_ir) == K_BYP) begin
            m_dr <= 32'd0; m_drlen <= 1;
          end
        SHDR: m_dr <= (m_dr >> 1) | (32'(td_i) << (m_drlen - 1));
        default: ;
      endcase
    end
  end

  always @(negedge tck or negedge trst_ni) begin
    if (!trst_ni) begin
      e_tdo <= 1'b0; e_oe <= 1'b0;
    end else begin
      e_oe <= (m_state == SHIR) || (m_state == SHDR);
      if (m_state == SHIR) e_tdo <= m_irsh[0];
      else if (m_state != SHDR) e_tdo <= 1'b0;
      else if (kind(m_ir) == K_DTMCS) e_tdo <= dtmcs_tdo_i;
      else if (kind(m_ir) == K_DMI) e_tdo <= dmi_tdo_i;
      else e_tdo <= m_dr[0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge tck) begin
    #3;
    chk("td_o", td_o, e_tdo);
    chk("tdo_oe_o", tdo_oe_o, e_oe);
    chk("dmi_clear_o", dmi_clear_o, m_state == TLR);
    chk("capture_o", capture_o, m_state == CDR);
    chk("shift_o", shift_o, m_state == SHDR);
    chk("update_o", update_o, m_state == UDR);
    chk("dtmcs_select_o", dtmcs_select_o, m_ir == 5'h10);
    chk("dmi_select_o", dmi_select_o, m_ir == 5'h11);
    chk("tdi_o", tdi_o, td_i);
    chk("tck_o", tck_o, tck);
  end

  task automatic clk(input logic tms, input logic tdi);
    tms_i = tms; td_i = tdi; dmi_tdo_i = 1'b0; dtmcs_tdo_i = 1'b0;
    @(posedge tck); #1;
  endtask

  task automatic clk_obs(input logic tms, input logic tdi, input logic ext, output logic o);
    tms_i = tms; td_i = tdi; dmi_tdo_i = ext; dtmcs_tdo_i = ~ext;
    @(posedge tck); #7;
    o = td_o;
  endtask

  task automatic ir_scan(input logic [4:0] code, output logic [4:0] seen);
    logic o;
    clk(1, 0); clk(1, 0); clk(0, 0);
    clk_obs(0, 0, 0, o); seen[0] = o;
    for (int k = 0; k < 4; k++) begin
      clk_obs(0, code[k], 0, o); seen[k+1] = o;
    end
    clk(1, code[4]); clk(1, 0); clk(0, 0);
  endtask

  task automatic dr_scan(input int n, input logic [31:0] din, input logic [31:0] ext,
                         output logic [31:0] seen);
    logic o;
    seen = '0;
    clk(1, 0); clk(0, 0);
    clk_obs(0, 0, ext[0], o); seen[0] = o;
    for (int k = 0; k < n - 1; k++) begin
      clk_obs(0, din[k], ext[k+1], o); seen[k+1] = o;
    end
    clk(1, din[n-1]); clk(1, 0); clk(0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  irs;
    logic [31:0] seen;
    logic [5:0]  seq_tms  = 6'b110000;
    logic [5:0]  exp_cap  = 6'b000001;
    logic [5:0]  exp_shft = 6'b001110;
    logic [5:0]  exp_upd  = 6'b100000;

    repeat (2) @(posedge tck);
    #1;
    chk("rst dmi_clear", dmi_clear_o, 1);
    chk("rst strobes", {capture_o, shift_o, update_o}, 0);
    chk("rst selects", {dtmcs_select_o, dmi_select_o}, 0);
    chk("rst td_o/oe", {td_o, tdo_oe_o}, 0);
    trst_ni = 1'b1;

    clk(0, 0);
    ir_scan(5'h10, irs);
    chk("dtmcs sel", {dtmcs_select_o, dmi_select_o}, 2'b10);
    clk(1, 0); clk(1, 0); clk(0, 0); clk(1, 0); clk(0, 0);
    repeat (4) clk(1, 0);
    chk("4 tms not tlr", dmi_clear_o, 0);
    clk(1, 0);
    chk("5 tms tlr", dmi_clear_o, 1);
    chk("tlr selects", {dtmcs_select_o, dmi_select_o}, 0);

    clk(0, 0);
    dr_scan(32, 32'hA5C31E69, 32'd0, seen);
    chk("dr after reset", seen, EXP_DR_AFTER_RESET);

    ir_scan(5'h11, irs);
    chk("ir capture out", irs, 5'b00101);
    chk("dmi sel", {dtmcs_select_o, dmi_select_o}, 2'b01);
    dr_scan(8, 32'h5A, 32'hB2, seen);
    chk("dmi tdo follow", seen, 32'hB2);

    ir_scan(5'h1F, irs);
    dr_scan(5, 32'b01101, 32'd0, seen);
    chk("bypass delay", seen, 32'b11010);

    ir_scan(5'h10, irs);
    clk(1, 0);
    for (int k = 0; k < 6; k++) begin
      clk(seq_tms[k], 0);
      chk("strobe capture", capture_o, exp_cap[k]);
      chk("strobe shift", shift_o, exp_shft[k]);
      chk("strobe update", update_o, exp_upd[k]);
      chk("strobe dtmcs sel", dtmcs_select_o, 1);
    end
    clk(0, 0);

    ir_scan(5'h01, irs);
    dr_scan(8, 32'hC3, 32'd0, seen);
    chk("ir 01 scan", seen, EXP_IR01_SCAN);

    ir_scan(5'h11, irs);
    clk(1, 0); clk(0, 0); clk(0, 1); clk(0, 1);
    #2;
    trst_ni = 1'b0;
    #1;
    chk("abort tlr", dmi_clear_o, 1);
    chk("abort dmi sel", dmi_select_o, 0);
    chk("abort oe", tdo_oe_o, 0);
    chk("abort td_o", td_o, 0);
    chk("abort update", update_o, 0);
    repeat (2) @(posedge tck);
    #1;
    tms_i = 1'b1;
    trst_ni = 1'b1;
    repeat (3) clk(1, 0);
    clk(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
